// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the HH:MM:SS timekeeping controller: mode encoding,
// BCD digit width and the mode-advance rule.
package clock_ctrl_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_MIN = 2'd1,
        MODE_SET_HR  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    // Mode sequence on each press of the mode button; the unused code recovers to RUN.
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:     next_mode = MODE_SET_MIN;
            MODE_SET_MIN: next_mode = MODE_SET_HR;
            MODE_SET_HR:  next_mode = MODE_RUN;
            default:      next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Button inputs and display outputs of the clock controller.
// master = button/display side, slave = the controller.
interface clock_ctrl_if;
    import clock_ctrl_pkg::*;

    logic             btn_mode;
    logic             btn_inc;
    logic [BCD_W-1:0] sec_lo;
    logic [BCD_W-1:0] sec_hi;
    logic [BCD_W-1:0] min_lo;
    logic [BCD_W-1:0] min_hi;
    logic [BCD_W-1:0] hr_lo;
    logic [BCD_W-1:0] hr_hi;
    logic [1:0]       mode;
    logic             blink;

    modport master (
        output btn_mode, btn_inc,
        input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc,
        output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, blink
    );

endinterface

// File: rtl/clock_ctrl_bcd_mod_cnt.sv
// Two-digit BCD counter modulo MOD with synchronous clear and a carry that
// fires on the increment that wraps the count back to 00.
module bcd_mod_cnt
    import clock_ctrl_pkg::*;
#(
    parameter int MOD = 60
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             en,
    input  logic             clr,
    output logic [BCD_W-1:0] lo,
    output logic [BCD_W-1:0] hi,
    output logic             carry
);

    localparam logic [BCD_W-1:0] MAX_LO = BCD_W'((MOD - 1) % 10);
    localparam logic [BCD_W-1:0] MAX_HI = BCD_W'((MOD - 1) / 10);

    logic at_max;

    // Wrap point is judged on both digits together, so 23 and 59 are told apart.
    assign at_max = (hi == MAX_HI) && (lo == MAX_LO);
    assign carry  = en && at_max;

    // Clear wins over increment; units 9 rolls over into the tens digit.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            lo <= '0;
            hi <= '0;
        end else if (clr) begin
            lo <= '0;
            hi <= '0;
        end else if (en) begin
            if (at_max) begin
                lo <= '0;
                hi <= '0;
            end else if (lo == BCD_W'(9)) begin
                lo <= '0;
                hi <= hi + BCD_W'(1);
            end else begin
                lo <= lo + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/clock_ctrl.sv
// HH:MM:SS timekeeping controller: 1 Hz prescaler, button edge detection,
// RUN/SET_MIN/SET_HR mode FSM and three cascaded BCD counters.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOUR_MOD = 24
) (
    input logic         clk,
    input logic         rs,
    clock_ctrl_if.slave bus
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(TICK_DIV / 2);

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic          tick;
    logic          btn_mode_q;
    logic          btn_inc_q;
    logic          mode_edge;
    logic          inc_edge;
    mode_e         mode_q;
    mode_e         mode_nxt;
    logic          blink_q;

    logic          sec_en;
    logic          sec_clr;
    logic          sec_carry;
    logic          min_en;
    logic          min_carry;
    logic          hr_en;
    logic          hr_carry_unused;

    assign tick      = (pcnt == PCNT_LAST);
    assign mode_edge = bus.btn_mode & ~btn_mode_q;
    assign inc_edge  = bus.btn_inc & ~btn_inc_q;

    // Next mode and next prescaler value; leaving SET_HR restarts the second.
    always_comb begin
        mode_nxt = mode_q;
        if (mode_edge) begin
            mode_nxt = next_mode(mode_q);
        end
        pcnt_nxt = pcnt + PW'(1);
        if (mode_edge && (mode_q == MODE_SET_HR)) begin
            pcnt_nxt = '0;
        end else if (tick) begin
            pcnt_nxt = '0;
        end
    end

    // Prescaler and button history registers for rising-edge detection.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            pcnt       <= '0;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
        end else begin
            pcnt       <= pcnt_nxt;
            btn_mode_q <= bus.btn_mode;
            btn_inc_q  <= bus.btn_inc;
        end
    end

    // Mode FSM with blink registered from the next mode and next prescaler count.
    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            mode_q  <= MODE_RUN;
            blink_q <= 1'b0;
        end else begin
            mode_q  <= mode_nxt;
            blink_q <= (mode_nxt != MODE_RUN) && (pcnt_nxt < PCNT_HALF);
        end
    end

    // A mode press in the same cycle as an inc press swallows the inc.
    assign sec_en  = tick && (mode_q == MODE_RUN);
    assign sec_clr = mode_edge && (mode_q == MODE_RUN);
    assign min_en  = sec_carry ||
                     ((mode_q == MODE_SET_MIN) && inc_edge && !mode_edge);
    assign hr_en   = (min_carry && (mode_q == MODE_RUN)) ||
                     ((mode_q == MODE_SET_HR) && inc_edge && !mode_edge);

    bcd_mod_cnt #(.MOD(60)) u_sec (
        .clk   (clk),
        .rs    (rs),
        .en    (sec_en),
        .clr   (sec_clr),
        .lo    (bus.sec_lo),
        .hi    (bus.sec_hi),
        .carry (sec_carry)
    );

    bcd_mod_cnt #(.MOD(60)) u_min (
        .clk   (clk),
        .rs    (rs),
        .en    (min_en),
        .clr   (1'b0),
        .lo    (bus.min_lo),
        .hi    (bus.min_hi),
        .carry (min_carry)
    );

    bcd_mod_cnt #(.MOD(HOUR_MOD)) u_hr (
        .clk   (clk),
        .rs    (rs),
        .en    (hr_en),
        .clr   (1'b0),
        .lo    (bus.hr_lo),
        .hi    (bus.hr_hi),
        .carry (hr_carry_unused)
    );

    assign bus.mode  = mode_q;
    assign bus.blink = blink_q;

endmodule
